gravity_collapse: RTL and testbench
===================================

// Module: gravity_collapse
// PURPOSE
//   Downstream stage of the elimination logic. It takes the board after elimination,
//   where removed cells are 0. Within each column, surviving tiles fall toward row ROWS-1
//   (the bottom). Empty columns are then removed and the remaining columns shift toward
//   column 0. The result is registered and handed back to the game FSM with a done pulse.
// PARAMETERS
//   ROWS  8  board rows; row 0 = top, row ROWS-1 = bottom
//   COLS  8  board columns; column 0 = left
//   CW    3  colour width; value 0 = empty cell, 1..2^CW-1 = tile colour
// PORTS
//   clk          in   1             system clock, rising edge
//   rst          in   1             asynchronous reset, active-low
//   start        in   1             request collapse of board_in (sampled only in IDLE)
//   board_in     in   ROWS*COLS*CW  cell (r,c) at bits [(r*COLS+c)*CW +: CW]
//   busy         out  1             high while the collapse is in progress
//   done         out  1             one-cycle pulse; board_out is valid from this cycle
//   board_out    out  ROWS*COLS*CW  collapsed board, same packing as board_in; held until next done
//   cleared_cnt  out  7             number of zero cells in the captured board_in (0..64)
//   all_clear    out  1             cleared_cnt == ROWS*COLS, updated with done
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; busy=0, done=0, board_out=0, cleared_cnt=0,
//     all_clear=0; internal work board and write pointer cleared. Any in-progress
//     collapse is abandoned and no done pulse is issued.
//   FSM states: IDLE -> DROP -> SHIFT -> DONE -> IDLE.
//   IDLE: on an edge with start=1, capture board_in into the work board, count its zero
//     cells into cnt_q, set col=0, and go to DROP. busy=1 from that edge onward.
//   DROP: each edge compacts work column col.
//     - Nonzero cells are packed into the bottom rows, keeping their top-to-bottom order.
//     - Zeros fill the top rows.
//     - col increments. After column COLS-1, set col=0 and wp=0, then go to SHIFT.
//     - Exactly COLS cycles.
//   SHIFT: each edge examines work column col (already dropped).
//     - The column is non-empty iff its bottom cell (row ROWS-1) is nonzero.
//     - If non-empty, copy it to column wp and increment wp; otherwise skip it.
//     - col increments. After the last column, go to DONE.
//     - Exactly COLS cycles.
//     - Columns wp..COLS-1 end all-zero: the block zero-fills them on the DONE edge.
//   DONE (entered at edge T0+2*COLS+1, where T0 is the start edge):
//     - Load board_out, cleared_cnt and all_clear.
//     - busy=0, done=1 for exactly one cycle.
//     - Next edge returns to IDLE unconditionally.
//     - start is ignored while in DONE.
//   start is ignored in DROP, SHIFT and DONE. No queueing: the request is simply dropped.
//   board_in may change after the capture edge without affecting the result.
//   Tile colour values pass through unchanged. No tile is created, destroyed or recoloured,
//     so the number of nonzero cells is preserved.
//   Latency: start edge to done high = 2*COLS+1 edges (17 for defaults); throughput one
//     board per 2*COLS+3 cycles.
//   cleared_cnt is 7 bits. It saturates naturally at 64, and ROWS*COLS must be <= 127.
// TESTING
//   T1 Column 0 rows 0..6 = 1..7, row 7 = 0; all other cells 2
//      -> col 0 out rows 0..7 = 0,1,2,..,7; cleared_cnt=1; all_clear=0.
//   T2 Column 3 all 0; all other cells 2
//      -> out cols 0..6 = all 2; col 7 all 0; cleared_cnt=8.
//   T3 board_in all 0
//      -> board_out all 0; cleared_cnt=64; all_clear=1; done still pulses.
//   T4 No zero cells; start at edge T0
//      -> board_out==board_in; done high only in the cycle after edge T0+17; busy high
//         for edges T0..T0+16.
//   T5 Extra start pulses during DROP/SHIFT/DONE -> exactly one done; result from first
//      capture. Drive rst=0 mid-DROP -> busy=0, board_out=0 immediately, no done.
//   T6 Mixed board: col 1 rows 6,7 = 0; col 5 all 0; others 4
//      -> col 0 all 4; col 1 rows 0,1 = 0 and rows 2..7 = 4; cols 2..4 ← cols 2..4;
//         cols 5,6 ← cols 6,7; col 7 all 0; cleared_cnt=10.

Source files
------------

// File: rtl/gravity_collapse.sv
// Gravity/collapse stage: drops surviving tiles to the bottom of each column, then
// squeezes out empty columns toward column 0 and reports how many cells were cleared.
module gravity_collapse #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CW   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROWS*COLS*CW-1:0]  board_in,
  output logic                     busy,
  output logic                     done,
  output logic [ROWS*COLS*CW-1:0]  board_out,
  output logic [6:0]               cleared_cnt,
  output logic                     all_clear
);

  localparam int NB = ROWS * COLS * CW;
  localparam int CB = $clog2(COLS + 1);

  // FILL is the wrap-up edge that zero-fills the vacated columns and loads the outputs,
  // so DONE (done high) is a real state in which start is ignored.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DROP  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [NB-1:0] work_q,  work_d;
  logic [CB-1:0] col_q,   col_d;
  logic [CB-1:0] wp_q,    wp_d;
  logic [6:0]    cnt_q,   cnt_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic [NB-1:0] out_q,   out_d;
  logic [6:0]    ccnt_q,  ccnt_d;
  logic          aclr_q,  aclr_d;

  logic [6:0]    zero_cnt;
  logic [CW-1:0] col_cells [ROWS];
  logic [CW-1:0] dropped   [ROWS];

  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (board_in[i*CW +: CW] == '0) zero_cnt = zero_cnt + 7'd1;
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      col_cells[r] = work_q[(r*COLS + int'(col_q))*CW +: CW];
    end
  end

  // Walk the column bottom-up, stacking each tile on the previous one; order is kept.
  always_comb begin
    int wr;
    wr = ROWS - 1;
    for (int r = 0; r < ROWS; r++) dropped[r] = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (col_cells[r] != '0) begin
        dropped[wr] = col_cells[r];
        wr = wr - 1;
      end
    end
  end

  // NOTE: every next-state signal takes its held value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    col_d   = col_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    ccnt_d  = ccnt_q;
    aclr_d  = aclr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = board_in;
          cnt_d   = zero_cnt;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_DROP;
        end
      end

      ST_DROP: begin
        for (int r = 0; r < ROWS; r++) begin
          work_d[(r*COLS + int'(col_q))*CW +: CW] = dropped[r];
        end
        if (col_q == CB'(COLS - 1)) begin
          col_d   = '0;
          wp_d    = '0;
          state_d = ST_SHIFT;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        // After the drop, a column is empty exactly when its bottom cell is empty.
        if (col_cells[ROWS-1] != '0) begin
          for (int r = 0; r < ROWS; r++) begin
            work_d[(r*COLS + int'(wp_q))*CW +: CW] = col_cells[r];
          end
          wp_d = wp_q + 1'b1;
        end
        if (col_q == CB'(COLS - 1)) begin
          state_d = ST_FILL;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      ST_FILL: begin
        for (int c = 0; c < COLS; c++) begin
          for (int r = 0; r < ROWS; r++) begin
            out_d[(r*COLS + c)*CW +: CW] =
              (CB'(c) < wp_q) ? work_q[(r*COLS + c)*CW +: CW] : '0;
          end
        end
        ccnt_d  = cnt_q;
        aclr_d  = (cnt_q == 7'(ROWS * COLS));
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the work board is ordinary flops, not a RAM, so it is cleared by reset
  // along with the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      col_q   <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      ccnt_q  <= '0;
      aclr_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      work_q  <= work_d;
      col_q   <= col_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      ccnt_q  <= ccnt_d;
      aclr_q  <= aclr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign board_out   = out_q;
  assign cleared_cnt = ccnt_q;
  assign all_clear   = aclr_q;

endmodule

// File: tb/tb_gravity_collapse.sv
// Directed bench for gravity_collapse: vector table of boards with hand-computed
// results, plus timing, start-during-busy and mid-collapse reset sequences.
module tb_gravity_collapse;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CW   = 3;
  localparam int NB   = ROWS * COLS * CW;
  localparam int LAT  = 2 * COLS + 1;

  typedef logic [NB-1:0] board_t;

  typedef struct {
    board_t     din;
    board_t     dout;
    logic [6:0] cnt;
    logic       ac;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  board_t     board_in;
  logic       busy;
  logic       done;
  board_t     board_out;
  logic [6:0] cleared_cnt;
  logic       all_clear;

  int pass_cnt;
  int total_cnt;

  gravity_collapse #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .board_in    (board_in),
    .busy        (busy),
    .done        (done),
    .board_out   (board_out),
    .cleared_cnt (cleared_cnt),
    .all_clear   (all_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic board_t fill(input logic [CW-1:0] v);
    board_t b;
    for (int i = 0; i < ROWS * COLS; i++) b[i*CW +: CW] = v;
    return b;
  endfunction

  function automatic board_t setc(input board_t b, input int r, input int c, input logic [CW-1:0] v);
    board_t t;
    t = b;
    t[(r*COLS + c)*CW +: CW] = v;
    return t;
  endfunction

  function automatic board_t setcol(input board_t b, input int c, input logic [CW-1:0] v);
    board_t t;
    t = b;
    for (int r = 0; r < ROWS; r++) t[(r*COLS + c)*CW +: CW] = v;
    return t;
  endfunction

  // Start one collapse; lat = edges from the start edge until done is seen (0 if never).
  task automatic run_board(input board_t b, output int lat);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    board_in = ~b;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t   vecs [6];
  board_t b;
  int     lat;
  int     bad;
  int     n_done;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    start     = 1'b0;
    board_in  = '0;

    // T1: column 0 holds 1..7 above an empty bottom cell.
    b = fill(3'd2);
    for (int r = 0; r < 7; r++) b = setc(b, r, 0, 3'(r + 1));
    b = setc(b, 7, 0, 3'd0);
    vecs[0].din = b;
    b = fill(3'd2);
    b = setc(b, 0, 0, 3'd0);
    for (int r = 1; r < 8; r++) b = setc(b, r, 0, 3'(r));
    vecs[0].dout = b;
    vecs[0].cnt  = 7'd1;
    vecs[0].ac   = 1'b0;

    // T2: empty column 3 is squeezed out.
    vecs[1].din  = setcol(fill(3'd2), 3, 3'd0);
    vecs[1].dout = setcol(fill(3'd2), 7, 3'd0);
    vecs[1].cnt  = 7'd8;
    vecs[1].ac   = 1'b0;

    // T3: everything cleared.
    vecs[2].din  = '0;
    vecs[2].dout = '0;
    vecs[2].cnt  = 7'd64;
    vecs[2].ac   = 1'b1;

    // No empty cells: board passes through untouched.
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b = setc(b, r, c, 3'(((r + c) % 7) + 1));
    vecs[3].din  = b;
    vecs[3].dout = b;
    vecs[3].cnt  = 7'd0;
    vecs[3].ac   = 1'b0;

    // T6: partial drop in column 1 plus empty column 5.
    b = setcol(fill(3'd4), 5, 3'd0);
    b = setc(b, 6, 1, 3'd0);
    vecs[4].din = setc(b, 7, 1, 3'd0);
    b = setcol(fill(3'd4), 7, 3'd0);
    b = setc(b, 0, 1, 3'd0);
    vecs[4].dout = setc(b, 1, 1, 3'd0);
    vecs[4].cnt  = 7'd10;
    vecs[4].ac   = 1'b0;

    // Two tiles alone in column 2 keep their order and slide to column 0.
    b = setc('0, 0, 2, 3'd5);
    vecs[5].din  = setc(b, 3, 2, 3'd6);
    b = setc('0, 6, 0, 3'd5);
    vecs[5].dout = setc(b, 7, 0, 3'd6);
    vecs[5].cnt  = 7'd62;
    vecs[5].ac   = 1'b0;

    // Reset state.
    #1;
    check("rst_busy", NB'(busy), '0);
    check("rst_done", NB'(done), '0);
    check("rst_board_out", board_out, '0);
    check("rst_cnt", NB'(cleared_cnt), '0);
    check("rst_all_clear", NB'(all_clear), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_board(vecs[i].din, lat);
      check($sformatf("v%0d_latency", i), NB'(lat), NB'(LAT));
      check($sformatf("v%0d_board_out", i), board_out, vecs[i].dout);
      check($sformatf("v%0d_cleared_cnt", i), NB'(cleared_cnt), NB'(vecs[i].cnt));
      check($sformatf("v%0d_all_clear", i), NB'(all_clear), NB'(vecs[i].ac));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_one_cycle", i), NB'(done), '0);
    end

    // T4: busy high after edges T0..T0+16, done high only after edge T0+17.
    @(negedge clk);
    board_in = vecs[3].din;
    start    = 1'b1;
    @(posedge clk);
    #1;
    check("t4_busy_at_t0", NB'(busy), NB'(1));
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk);
      #1;
      if (busy !== (k <= LAT - 1)) bad++;
      if (done !== (k == LAT)) bad++;
    end
    check("t4_busy_done_timing", NB'(bad), '0);
    check("t4_board_out", board_out, vecs[3].din);

    // T5: start held high through the whole collapse with board_in changed after capture.
    @(negedge clk);
    board_in = vecs[4].din;
    start    = 1'b1;
    @(negedge clk);
    board_in = '0;
    n_done = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("t5_single_done", NB'(n_done), NB'(1));
    check("t5_first_capture", board_out, vecs[4].dout);
    check("t5_cnt", NB'(cleared_cnt), NB'(10));

    // Reset in the middle of DROP abandons the collapse.
    @(negedge clk);
    board_in = vecs[0].din;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", NB'(busy), '0);
    check("mid_rst_board_out", board_out, '0);
    check("mid_rst_cnt", NB'(cleared_cnt), '0);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("mid_rst_no_done", NB'(n_done), '0);
    check("mid_rst_idle", NB'(busy), '0);

    // Recovery after the abandoned run.
    run_board(vecs[1].din, lat);
    check("recover_latency", NB'(lat), NB'(LAT));
    check("recover_board_out", board_out, vecs[1].dout);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
